fb_write_scheduler: RTL and testbench
=====================================

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, RAM address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM data width.
REQ-003 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have host_valid  input  1  host write request.
REQ-006 SHALL have host_ready  output  1  host write accepted this cycle if host_valid.
REQ-007 SHALL have host_addr  input  ADDR_WIDTH  host write address.
REQ-008 SHALL have host_data  input  DATA_WIDTH  host write data.
REQ-009 SHALL have clear_start  input  1  single-cycle request to fill whole RAM.
REQ-010 SHALL have clear_value  input  DATA_WIDTH  fill value, sampled with clear_start.
REQ-011 SHALL have clear_busy  output  1  high while fill is in progress.
REQ-012 SHALL have clear_done  output  1  one-cycle pulse after final fill write.
REQ-013 SHALL have ram_write_addr  output  ADDR_WIDTH  to sync_pdp_ram write port.
REQ-014 SHALL have ram_write_data  output  DATA_WIDTH  to sync_pdp_ram write port.
REQ-015 SHALL have ram_write_en  output  1  to sync_pdp_ram write port.

Function
REQ-016 SHALL issue at most one RAM write per cycle; ram_write_* registered.
REQ-017 SHALL accept a host write on cycle N when host_valid && host_ready; ram_write_en=1 with that addr/data on cycle N+1 (latency 1).
REQ-018 SHALL derive host_ready from registered state only, never from host_valid.
REQ-019 SHALL drive ram_write_en=0 on any cycle following one with no grant; ram_write_addr/data hold last value.
REQ-020 SHALL implement fill FSM states IDLE, FILL, DONE.
REQ-021 IDLE: clear_start=1 latches clear_value, loads fill counter 0, next state FILL.
REQ-022 FILL: each granted cycle writes (counter, latched value), counter+1; grant at counter=DEPTH-1 -> DONE.
REQ-023 DONE: clear_done=1 for exactly one cycle, next state IDLE.
REQ-024 clear_busy SHALL be 1 exactly in FILL and DONE.
REQ-025 clear_start outside IDLE SHALL be ignored (no restart, no queueing).
REQ-026 In IDLE host_ready SHALL be 1; clear_start and host write on same cycle: host write accepted that cycle, fill begins next cycle.
REQ-027 Fill counter SHALL not wrap: exactly DEPTH fill writes, addresses 0..DEPTH-1 ascending, each once.
REQ-028 Host writes interleaved during FILL SHALL land in RAM order of grant; a later fill write may overwrite host data at same address (defined behaviour).

Reset
REQ-029 On reset edge: FSM=IDLE, fill counter=0, ram_write_en=0, ram_write_addr=0, ram_write_data=0, clear_done=0, clear_busy=0, arbitration pointer=host-last.
REQ-030 Reset during FILL SHALL abort without clear_done pulse and without further RAM writes.
REQ-031 host_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-032 Macro FB_ROUND_ROBIN_EN defined: in FILL, when host_valid and fill both pending, grant alternates (grant whichever was not granted last); host_ready=1 in FILL only on host's turn; fill with no host_valid proceeds every cycle.
REQ-033 Macro FB_ROUND_ROBIN_EN undefined: fill has strict priority; host_ready=0 throughout FILL and DONE; fill completes in exactly DEPTH cycles.

Verification
REQ-034 Reset, then host write addr=1 data=0x2a -> next cycle ram_write_en=1, addr=1, data=0x2a; following idle cycle ram_write_en=0.
REQ-035 clear_start with clear_value=0x55, no host traffic -> 1024 consecutive writes addr 0..1023 data 0x55, clear_done pulse one cycle after addr 1023, clear_busy falls same cycle as pulse ends.
REQ-036 clear_start + host write addr=5 data=0x11 same cycle -> addr 5 written first, then fill from 0; RAM read of addr 5 after done returns 0x55.
REQ-037 FB_ROUND_ROBIN_EN, host_valid held high during fill -> writes alternate fill/host; fill done after 2048 cycles; undefined -> host_ready=0 until done, 1024 cycles.
REQ-038 Reset asserted at fill counter 300 -> no writes after reset edge, no clear_done, host_ready=1 next cycle.
REQ-039 clear_start re-pulsed at counter 100 with clear_value=0xff -> ignored; all fill writes remain 0x55.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: arbitrates host writes and a whole-RAM fill onto one registered write port.
// Define FB_ROUND_ROBIN_EN to alternate host and fill grants during a fill; otherwise fill has strict priority.
module fb_write_scheduler #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_en
);
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;
  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt, r_addr;
  logic [DATA_WIDTH-1:0] r_val, w_val_nxt, r_data;
  logic                  r_we, w_host_gnt, w_fill_gnt;
`ifdef FB_ROUND_ROBIN_EN
  logic r_last_fill;
  // host may only contend during a fill when the previous grant went to the fill side
  assign host_ready = (r_state != S_FILL) || r_last_fill;
  always_ff @(posedge clk)
    if (reset) r_last_fill <= 1'b0;
    else if (w_host_gnt) r_last_fill <= 1'b0;
    else if (w_fill_gnt) r_last_fill <= 1'b1;
`else
  assign host_ready = (r_state == S_IDLE);
`endif
  assign w_host_gnt     = host_valid && host_ready;
  assign w_fill_gnt     = (r_state == S_FILL) && !w_host_gnt;
  assign clear_busy     = (r_state != S_IDLE);
  assign clear_done     = (r_state == S_DONE);
  assign ram_write_addr = r_addr;
  assign ram_write_data = r_data;
  assign ram_write_en   = r_we;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_val_nxt   = r_val;
    if (r_state == S_IDLE && clear_start) begin
      w_state_nxt = S_FILL;
      w_cnt_nxt   = '0;
      w_val_nxt   = clear_value;
    end else if (w_fill_gnt) begin
      w_cnt_nxt   = (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
      w_state_nxt = (r_cnt == LAST) ? S_DONE : S_FILL;
    end else if (r_state == S_DONE) begin
      w_state_nxt = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_val   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_val   <= w_val_nxt;
      r_we    <= w_host_gnt || w_fill_gnt;
      if (w_host_gnt) begin
        r_addr <= host_addr;
        r_data <= host_data;
      end else if (w_fill_gnt) begin
        r_addr <= r_cnt;
        r_data <= r_val;
      end
    end
  end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler: directed checks of host writes, fill, collisions, aborts and ignored restarts.
module tb_fb_write_scheduler;
`ifdef FB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b1;
  logic       host_valid = 1'b0, host_ready, clear_start = 1'b0, clear_busy, clear_done, ram_write_en;
  logic [9:0] host_addr = '0, ram_write_addr;
  logic [7:0] host_data = '0, clear_value = '0, ram_write_data;
  logic [7:0] mem [1024];
  int total = 0, bad = 0;
  fb_write_scheduler dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data), .clear_start(clear_start),
    .clear_value(clear_value), .clear_busy(clear_busy), .clear_done(clear_done),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data), .ram_write_en(ram_write_en)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_en", ram_write_en, 0);
    chk("rst_addr", ram_write_addr, 0);
    chk("rst_data", ram_write_data, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    reset = 1'b0;
    chk("rst_ready", host_ready, 1);
    host_valid = 1'b1; host_addr = 10'd1; host_data = 8'h2a;
    tick();
    host_valid = 1'b0;
    chk("host_wr", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, 10'd1, 8'h2a});
    tick();
    chk("host_idle", {ram_write_en, ram_write_addr, ram_write_data}, {1'b0, 10'd1, 8'h2a});
    // fill at 0x55 colliding with a host write to addr 5, plus an ignored restart at counter 100
    clear_start = 1'b1; clear_value = 8'h55;
    host_valid = 1'b1; host_addr = 10'd5; host_data = 8'h11;
    tick();
    clear_start = 1'b0; host_valid = 1'b0;
    chk("coll_host", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, 10'd5, 8'h11});
    chk("coll_busy", clear_busy, 1);
    for (int i = 0; i < 1024; i++) begin
      clear_start = 1'b0;
      tick();
      chk("fill_wr", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, i[9:0], 8'h55});
      chk("fill_done", clear_done, (i == 1023) ? 1 : 0);
      chk("fill_busy", clear_busy, 1);
      chk("fill_ready", host_ready, RR ? 1 : 0);
      if (i == 99) begin
        clear_start = 1'b1;
        clear_value = 8'hff;
      end
    end
    clear_start = 1'b0;
    tick();
    chk("post_en", ram_write_en, 0);
    chk("post_done", clear_done, 0);
    chk("post_busy", clear_busy, 0);
    chk("post_ready", host_ready, 1);
    tick();
    chk("restart_ign", clear_busy, 0);
    chk("mem5", mem[5], 8'h55);
    chk("mem0", mem[0], 8'h55);
    chk("mem100", mem[100], 8'h55);
    chk("mem1023", mem[1023], 8'h55);
    // host held high during a fill, from a fresh reset so the fill side takes the first turn
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_start = 1'b1; clear_value = 8'h33;
    tick();
    clear_start = 1'b0;
    host_valid = 1'b1; host_addr = 10'd3; host_data = 8'h77;
    for (int k = 0; k < (RR ? 2048 : 1024); k++) begin
      tick();
      if (RR && k % 2 == 1)
        chk("hold_host", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, 10'd3, 8'h77});
      else
        chk("hold_fill", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, RR ? k[10:1] : k[9:0], 8'h33});
      chk("hold_done", clear_done, (k == (RR ? 2046 : 1023)) ? 1 : 0);
      chk("hold_ready", host_ready, RR ? ((k % 2 == 0 || k == 2047) ? 1 : 0) : 0);
    end
    host_valid = 1'b0;
    tick();
    tick();
    chk("hold_busy", clear_busy, 0);
    chk("hold_mem1000", mem[1000], 8'h33);
    // reset while the counter sits at 300
    clear_start = 1'b1; clear_value = 8'h99;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    chk("abort_last", {ram_write_en, ram_write_addr, ram_write_data}, {1'b1, 10'd299, 8'h99});
    reset = 1'b1;
    tick();
    chk("abort_en", ram_write_en, 0);
    chk("abort_busy", clear_busy, 0);
    reset = 1'b0;
    chk("abort_ready", host_ready, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_quiet", {ram_write_en, clear_done, clear_busy}, 3'b000);
    end
    chk("abort_mem299", mem[299], 8'h99);
    chk("abort_mem300", mem[300], 8'h33);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
